// File: rtl/instr_fetch_buffer_if.sv
// ============================================================================
// Module   : instr_fetch_buffer_if
// Purpose  : Core-side and ICCM-side signals of the instruction fetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_buffer_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  fetch_en_i;
    logic                  branch_i;
    logic [ADDR_WIDTH-1:0] branch_addr_i;
    logic                  instr_valid_o;
    logic [31:0]           instr_rdata_o;
    logic [ADDR_WIDTH-1:0] instr_addr_o;
    logic                  instr_ready_i;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_we_o;
    logic [3:0]            mem_wmask_o;
    logic [31:0]           mem_wdata_o;
    logic [31:0]           mem_rdata_i;
    logic                  mem_rvalid_i;
    logic                  busy_o;

    // The fetch buffer masters both the ICCM bus and the instruction stream.
    modport master (
        input  fetch_en_i, branch_i, branch_addr_i, instr_ready_i,
               mem_rdata_i, mem_rvalid_i,
        output instr_valid_o, instr_rdata_o, instr_addr_o, mem_req_o,
               mem_addr_o, mem_we_o, mem_wmask_o, mem_wdata_o, busy_o
    );

    modport slave (
        output fetch_en_i, branch_i, branch_addr_i, instr_ready_i,
               mem_rdata_i, mem_rvalid_i,
        input  instr_valid_o, instr_rdata_o, instr_addr_o, mem_req_o,
               mem_addr_o, mem_we_o, mem_wmask_o, mem_wdata_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_buffer.sv
// ============================================================================
// Module   : instr_fetch_buffer
// Purpose  : Sequential ICCM prefetcher with a small FIFO and branch flush.
//            Define FETCH_BUF_BYPASS_EN to forward responses into an empty FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_buffer #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    instr_fetch_buffer_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = ADDR_WIDTH + 32;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_fetch_addr;
    logic [ADDR_WIDTH-1:0] r_inflight_addr;
    logic                  r_inflight;
    logic [EW-1:0]         r_fifo [DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_issue;
    logic [CW-1:0]         w_credit;
    logic                  w_capture;
    logic                  w_fifo_empty;
    logic                  w_bypass;
    logic                  w_valid;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [EW-1:0]         w_rsp_entry;
    logic [EW-1:0]         w_head;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Credits count both stored words and the outstanding request.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_credit    = r_count + {{(CW-1){1'b0}}, r_inflight};
        case (r_state)
            ST_BOOT: w_state_nxt = bus.fetch_en_i ? ST_RUN : ST_HALT;
            ST_RUN: begin
                w_issue = !bus.branch_i && (w_credit < CW'(DEPTH));
                if (!bus.fetch_en_i) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (bus.fetch_en_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_fetch_addr    <= BOOT_ADDR;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
        end else begin
            r_inflight <= w_issue;
            if (bus.branch_i) begin
                r_fetch_addr <= bus.branch_addr_i;
            end else if (r_state == ST_BOOT) begin
                r_fetch_addr <= BOOT_ADDR;
            end else if (w_issue) begin
                r_fetch_addr <= r_fetch_addr + ADDR_WIDTH'(1);
            end
            if (w_issue) begin
                r_inflight_addr <= r_fetch_addr;
            end
        end
    end

    // Gating by r_inflight drops responses to requests issued before a reset.
    assign w_capture    = bus.mem_rvalid_i && r_inflight && !bus.branch_i;
    assign w_fifo_empty = (r_count == '0);
    assign w_rsp_entry  = {r_inflight_addr, bus.mem_rdata_i};

`ifdef FETCH_BUF_BYPASS_EN
    assign w_bypass = w_fifo_empty && w_capture;
    assign w_head   = w_fifo_empty ? w_rsp_entry : r_fifo[r_rd_ptr];
`else
    assign w_bypass = 1'b0;
    assign w_head   = r_fifo[r_rd_ptr];
`endif

    assign w_valid  = !w_fifo_empty || w_bypass;
    assign w_accept = w_valid && bus.instr_ready_i;
    assign w_pop    = w_accept && !w_fifo_empty;
    assign w_push   = w_capture && !(w_bypass && bus.instr_ready_i);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_rsp_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.branch_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(w_push && (r_count == CW'(DEPTH))));
        end
    end

    assign bus.instr_valid_o = w_valid;
    assign bus.instr_rdata_o = w_valid ? w_head[31:0] : 32'd0;
    assign bus.instr_addr_o  = w_valid ? w_head[EW-1:32] : '0;
    assign bus.mem_req_o     = w_issue;
    assign bus.mem_addr_o    = r_fetch_addr;
    assign bus.mem_we_o      = 1'b0;
    assign bus.mem_wmask_o   = 4'd0;
    assign bus.mem_wdata_o   = 32'd0;
    assign bus.busy_o        = !w_fifo_empty || r_inflight;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_buffer.sv
// ============================================================================
// Module   : tb_instr_fetch_buffer
// Purpose  : Directed self-checking bench for instr_fetch_buffer (DEPTH 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_buffer;
    localparam int AW = 12;
`ifdef FETCH_BUF_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic clk;
    logic rst_ni;
    logic inject_rsp;
    int   n_tests;
    int   n_fail;

    instr_fetch_buffer_if #(.ADDR_WIDTH(AW)) bus ();

    instr_fetch_buffer #(
        .DEPTH     (4),
        .ADDR_WIDTH(AW),
        .BOOT_ADDR (12'h000)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ICCM model: word n holds 0x1000_0000 + n, one-cycle read latency.
    always @(posedge clk) begin
        bus.mem_rvalid_i <= bus.mem_req_o || inject_rsp;
        bus.mem_rdata_i  <= 32'h1000_0000 + {20'd0, bus.mem_addr_o};
    end

    typedef struct {
        logic          fe;
        logic          rdy;
        logic          br;
        logic [AW-1:0] baddr;
        logic          req;
        logic [AW-1:0] maddr;
        logic          v;
        logic [AW-1:0] ia;
        logic          busy;
    } vec_t;

    vec_t vt [28];

    function automatic vec_t mk(input logic fe, input logic rdy, input logic br,
                                input logic [AW-1:0] baddr, input logic req,
                                input logic [AW-1:0] maddr, input logic v,
                                input logic [AW-1:0] ia, input logic busy);
        vec_t r;
        r.fe = fe; r.rdy = rdy; r.br = br; r.baddr = baddr;
        r.req = req; r.maddr = maddr; r.v = v; r.ia = ia; r.busy = busy;
        return r;
    endfunction

    function automatic logic [31:0] word_of(input logic v, input logic [AW-1:0] a);
        return v ? (32'h1000_0000 + {20'd0, a}) : 32'd0;
    endfunction

    task automatic check(input string name, input int cyc,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic fe, input logic rdy, input logic br,
                         input logic [AW-1:0] baddr);
        @(negedge clk);
        bus.fetch_en_i    = fe;
        bus.instr_ready_i = rdy;
        bus.branch_i      = br;
        bus.branch_addr_i = baddr;
        #1;
    endtask

    task automatic check_instr(input string name, input int cyc,
                               input logic v, input logic [AW-1:0] ia);
        check({name, "_valid"}, cyc, {31'd0, bus.instr_valid_o}, {31'd0, v});
        check({name, "_addr"},  cyc, {20'd0, bus.instr_addr_o}, v ? {20'd0, ia} : 32'd0);
        check({name, "_rdata"}, cyc, bus.instr_rdata_o, word_of(v, ia));
    endtask

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        rst_ni            = 1'b0;
        inject_rsp        = 1'b0;
        bus.fetch_en_i    = 1'b0;
        bus.instr_ready_i = 1'b0;
        bus.branch_i      = 1'b0;
        bus.branch_addr_i = '0;

        //          fe rdy br baddr    req maddr   v  ia      busy
        vt[0]  = mk(1, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 0);
        vt[1]  = mk(1, 1, 0, 12'h000, 1, 12'h000, 0, 12'h000, 0);
        vt[2]  = mk(1, 1, 0, 12'h000, 1, 12'h001, 0, 12'h000, 1);
        vt[3]  = mk(1, 1, 0, 12'h000, 1, 12'h002, 1, 12'h000, 1);
        vt[4]  = mk(1, 1, 0, 12'h000, 1, 12'h003, 1, 12'h001, 1);
        vt[5]  = mk(1, 1, 0, 12'h000, 1, 12'h004, 1, 12'h002, 1);
        vt[6]  = mk(1, 0, 0, 12'h000, 1, 12'h005, 1, 12'h003, 1);
        vt[7]  = mk(1, 0, 0, 12'h000, 1, 12'h006, 1, 12'h003, 1);
        vt[8]  = mk(1, 0, 0, 12'h000, 0, 12'h007, 1, 12'h003, 1);
        vt[9]  = mk(1, 0, 0, 12'h000, 0, 12'h007, 1, 12'h003, 1);
        vt[10] = mk(1, 0, 0, 12'h000, 0, 12'h007, 1, 12'h003, 1);
        vt[11] = mk(1, 1, 0, 12'h000, 0, 12'h007, 1, 12'h003, 1);
        vt[12] = mk(1, 1, 0, 12'h000, 1, 12'h007, 1, 12'h004, 1);
        vt[13] = mk(1, 1, 0, 12'h000, 1, 12'h008, 1, 12'h005, 1);
        vt[14] = mk(1, 1, 0, 12'h000, 1, 12'h009, 1, 12'h006, 1);
        vt[15] = mk(1, 1, 1, 12'h100, 0, 12'h00A, 1, 12'h007, 1);
        vt[16] = mk(1, 1, 0, 12'h000, 1, 12'h100, 0, 12'h000, 0);
        vt[17] = mk(1, 1, 0, 12'h000, 1, 12'h101, 0, 12'h000, 1);
        vt[18] = mk(1, 1, 0, 12'h000, 1, 12'h102, 1, 12'h100, 1);
        vt[19] = mk(0, 1, 0, 12'h000, 1, 12'h103, 1, 12'h101, 1);
        vt[20] = mk(0, 1, 0, 12'h000, 0, 12'h104, 1, 12'h102, 1);
        vt[21] = mk(0, 1, 0, 12'h000, 0, 12'h104, 1, 12'h103, 1);
        vt[22] = mk(0, 1, 0, 12'h000, 0, 12'h104, 0, 12'h000, 0);
        vt[23] = mk(0, 1, 0, 12'h000, 0, 12'h104, 0, 12'h000, 0);
        vt[24] = mk(1, 1, 0, 12'h000, 0, 12'h104, 0, 12'h000, 0);
        vt[25] = mk(1, 1, 0, 12'h000, 1, 12'h104, 0, 12'h000, 0);
        vt[26] = mk(1, 1, 0, 12'h000, 1, 12'h105, 0, 12'h000, 1);
        vt[27] = mk(1, 1, 0, 12'h000, 1, 12'h106, 1, 12'h104, 1);

        repeat (3) @(negedge clk);
        rst_ni = 1'b1;

        // Boot, streaming, backpressure, branch with response in flight, halt.
        for (int i = 0; i < 28; i++) begin
            drive(vt[i].fe, vt[i].rdy, vt[i].br, vt[i].baddr);
`ifndef FETCH_BUF_BYPASS_EN
            check("tbl_req",  i, {31'd0, bus.mem_req_o}, {31'd0, vt[i].req});
            check("tbl_maddr", i, {20'd0, bus.mem_addr_o}, {20'd0, vt[i].maddr});
            check("tbl_busy", i, {31'd0, bus.busy_o}, {31'd0, vt[i].busy});
            check_instr("tbl", i, vt[i].v, vt[i].ia);
`else
            if (i < 3) begin
                check("boot_req", i, {31'd0, bus.mem_req_o}, {31'd0, vt[i].req});
                check_instr("boot_byp", i, (i == 2), 12'h000);
            end
`endif
            check("tbl_wr_ties", i, {bus.mem_wdata_o[30:0], bus.mem_we_o},
                  32'd0 | {27'd0, bus.mem_wmask_o, 1'b0});
        end

        // Wrap: redirect near the top of the address space.
        for (int k = 0; k < 8; k++) begin
            logic [AW-1:0] ea;
            logic [AW-1:0] ei;
            drive(1'b1, 1'b1, (k == 0), 12'hFFE);
            ea = 12'hFFE + AW'(k - 1);
            ei = 12'hFFE + AW'(k - LAT);
            check("wrap_req", k, {31'd0, bus.mem_req_o}, {31'd0, (k != 0)});
            if (k != 0) begin
                check("wrap_maddr", k, {20'd0, bus.mem_addr_o}, {20'd0, ea});
                check_instr("wrap", k, (k >= LAT), ei);
            end
        end

        // Fill three entries with a request in flight, then reset for one cycle.
        drive(1'b1, 1'b0, 1'b1, 12'h040);
        for (int k = 1; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b0, 12'h000);
            check("fill_req", k, {31'd0, bus.mem_req_o}, 32'd1);
        end
        @(negedge clk);
        rst_ni     = 1'b0;
        inject_rsp = 1'b1;
        #1;
        check("prerst_busy", 0, {31'd0, bus.busy_o}, 32'd1);
        check("prerst_req", 0, {31'd0, bus.mem_req_o}, 32'd0);
        check_instr("prerst", 0, 1'b1, 12'h040);

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rst_ni            = 1'b1;
            inject_rsp        = 1'b0;
            bus.fetch_en_i    = 1'b1;
            bus.instr_ready_i = 1'b1;
            bus.branch_i      = 1'b0;
            #1;
            check("rst_req", k, {31'd0, bus.mem_req_o}, {31'd0, (k >= 1)});
            if (k >= 1) begin
                check("rst_maddr", k, {20'd0, bus.mem_addr_o}, k - 1);
            end
            check("rst_busy", k, {31'd0, bus.busy_o}, {31'd0, (k >= 2)});
            check_instr("rst", k, (k >= LAT), AW'(k - LAT));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

Prefetch stage sitting directly upstream of the instruction memory (ICCM) wrapper. It generates sequential word-address fetch requests to the ICCM, captures the returned words into a small FIFO, and hands them to the core through a valid/ready interface. Branch redirects flush the FIFO and discard any in-flight response.

## Interface
- `DEPTH`, default 4: FIFO entries. Power of two, minimum 2.
- `ADDR_WIDTH`, default 12: word-address width. Matches the ICCM address.
- `BOOT_ADDR`, default 0: first word address fetched after reset.

Ports:
- `clk_i`, in, 1: clock. Only one clock; all logic on the rising edge.
- `rst_ni`, in, 1: reset. Synchronous, active-low.
- `fetch_en_i`, in, 1: permits issuing new requests.
- `branch_i`, in, 1: redirect strobe.
- `branch_addr_i`, in, ADDR_WIDTH: redirect target word address.
- `instr_valid_o`, out, 1: head entry valid.
- `instr_rdata_o`, out, 32: head instruction word. 0 when not valid.
- `instr_addr_o`, out, ADDR_WIDTH: word address of head. 0 when not valid.
- `instr_ready_i`, in, 1: core accepts the head this cycle.
- `mem_req_o`, out, 1: ICCM request.
- `mem_addr_o`, out, ADDR_WIDTH: ICCM word address.
- `mem_we_o`, out, 1: tied 0.
- `mem_wmask_o`, out, 4: tied 0.
- `mem_wdata_o`, out, 32: tied 0.
- `mem_rdata_i`, in, 32: ICCM read data. Qualified by `mem_rvalid_i`.
- `mem_rvalid_i`, in, 1: response valid. Arrives exactly 1 cycle after the request.
- `busy_o`, out, 1: FIFO non-empty or a request is in flight.

## Operation
- **FSM states:**
  - BOOT: entered on reset. Lasts one cycle. Loads `fetch_addr` = `BOOT_ADDR`. No request. Next state is RUN if `fetch_en_i`, else HALT.
  - RUN: issues requests. Goes to HALT when `fetch_en_i`=0.
  - HALT: issues no requests; an in-flight response is still captured. Goes to RUN when `fetch_en_i`=1.
- **Issue condition:** `mem_req_o` = RUN && !`branch_i` && (`count` + `inflight`) < DEPTH.
  - The condition is combinational from registered state; `mem_addr_o` = `fetch_addr`.
  - On issue, `fetch_addr` increments by 1 and wraps modulo 2^ADDR_WIDTH (max address → 0).
  - On issue, `inflight` is set for the next cycle; otherwise it is cleared. At most one request is ever outstanding.
- **Capture:** `mem_rvalid_i` && !`branch_i` pushes {address, `mem_rdata_i`}. The address comes from an `inflight_addr` register captured at issue.
  - The credit rule guarantees no overflow. A push into a full FIFO is an assertion failure.
- **Pop:** `instr_valid_o` && `instr_ready_i`. Simultaneous push and pop leaves `count` unchanged.
- **Branch (`branch_i`=1), any state except BOOT:**
  - FIFO cleared (`count` → 0).
  - A response arriving this cycle is dropped.
  - No request this cycle.
  - `fetch_addr` ← `branch_addr_i`. `inflight` ← 0.
  - The head shown this cycle may still be popped by the core but is discarded anyway. The core must ignore it.
  - Branch in BOOT: target overrides `BOOT_ADDR`.
  - Branch and `fetch_en_i`=0 together: the address is loaded and the state goes to HALT.
- **Reset mid-operation:** all state is cleared. A response arriving in the cycle after reset is ignored because `inflight`=0; responses are gated by `inflight`.
- **Reset values:** `instr_valid_o`=0, `instr_rdata_o`=0, `instr_addr_o`=0, `mem_req_o`=0, `busy_o`=0, FSM=BOOT, `count`=0, `inflight`=0.

## Timing
- Cycle 0 is the first cycle with `rst_ni`=1 (BOOT).
- Cycle 1: first `mem_req_o` at `BOOT_ADDR`.
- Cycle 2: `mem_rvalid_i`.
- Cycle 3: `instr_valid_o` (2 cycles in bypass mode, see Configuration).
- Redirect latency: `branch_i` at cycle t → request to the target at t+1 → instruction visible at t+3 (t+2 with bypass).
- Steady-state throughput: 1 instruction/cycle while `instr_ready_i`=1 and DEPTH≥2.
- Backpressure: with `instr_ready_i` held 0, requests stop once `count` + `inflight` = DEPTH. Exactly DEPTH words are held.

## Configuration
- **`FETCH_BUF_BYPASS_EN` defined:**
  - When the FIFO is empty and a response is captured, the response drives `instr_valid_o`/`instr_rdata_o`/`instr_addr_o` combinationally in the same cycle.
  - If the core accepts it, it is not written.
  - A dropped (branch) response is never bypassed.
- **Undefined:** every response is written to the FIFO and becomes visible the next cycle. Outputs are purely registered or FIFO-mux driven.

## Test plan
- **Boot:** release reset with `fetch_en_i`=1, `instr_ready_i`=1, ICCM word n = 0x1000_0000+n.
  - Expect requests at addresses 0, 1, 2… from cycle 1.
  - Expect `instr_valid_o` at cycle 3 (2 with bypass) with `instr_rdata_o`=0x1000_0000, then one word per cycle.
- **Backpressure:** hold `instr_ready_i`=0.
  - Expect exactly 4 requests (addresses 0–3) and `mem_req_o`=0 thereafter.
  - Raise ready: expect words 0,1,2,3 in order, and fetching resumes at address 4.
- **Branch with response in flight:** pulse `branch_i` with `branch_addr_i`=0x100 in the cycle the response for 0x005 returns.
  - The 0x005 word is never presented.
  - Next request is at 0x100; the next valid `instr_addr_o`=0x100.
- **Wrap:** branch to 0xFFE.
  - Expect the request sequence 0xFFE, 0xFFF, 0x000, 0x001, and matching `instr_addr_o` values.
- **Halt:** drop `fetch_en_i` for 5 cycles mid-stream.
  - The in-flight word is still captured. No requests during HALT.
  - Resume at the next sequential address. `busy_o` falls once the FIFO drains.
- **Reset mid-operation:** assert `rst_ni`=0 for one cycle with the FIFO at 3 entries and a request in flight.
  - All outputs are 0 after the reset cycle. The stale response is ignored.
  - Fetch restarts at `BOOT_ADDR`.
